// File: rtl/sm_pkg.sv
// sm_pkg: shared definitions for the stepper-motor ramp controller and the
// downstream pulse stage it feeds (state encodings, default ramp parameters,
// pulse-stage timing constants).
package sm_pkg;

  // One-hot controller states; a single set bit identifies the state.
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    ACCEL  = 5'b00010,
    CRUISE = 5'b00100,
    DECEL  = 5'b01000,
    STOP   = 5'b10000
  } sm_state_e;

  // Default ramp controller parameters (periods in clk cycles).
  localparam int SM_SIZE_DEF    = 16;
  localparam int SM_P_START_DEF = 1000;
  localparam int SM_P_MIN_DEF   = 100;
  localparam int SM_P_DEC_DEF   = 10;

  // Pulse stage constants, 50 MHz system clock.
  localparam int SM_CLK_HZ         = 50_000_000;
  localparam int SM_PULSE_HIGH_CYC = 100;  // 2 us step pulse high time
  localparam int SM_DIR_SETUP_CYC  = 25;   // 500 ns direction setup before a pulse

endpackage

// File: rtl/sm_step_edge.sv
// sm_step_edge: rising-edge detector for the step pulse fed back from the
// pulse stage. step_evt is high for the one cycle in which drv_step is high
// and its registered previous value is low.
module sm_step_edge (
  input  logic clk,
  input  logic rst,
  input  logic drv_step,
  output logic step_evt
);

  logic prev_q;

  // Remember last cycle's drv_step level.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= drv_step;
    end
  end

  assign step_evt = drv_step & ~prev_q;

endmodule

// File: rtl/sm_ramp_ctrl.sv
// sm_ramp_ctrl: trapezoidal speed ramp for a stepper motor. Accepts a move
// command (step count + direction), then hands a period n to the downstream
// pulse stage, shortening it on every step while accelerating, holding it
// while cruising, and lengthening it again so the motor is back at the start
// period when the last step is issued.
//
// Optional build macro: SM_RAMP_ABORT_EN adds an abort input that turns an
// accelerating or cruising move into an immediate deceleration.
//
// Command handshake: a command is taken on a clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high exactly while the FSM is in
// IDLE; cmd_valid seen while cmd_ready is low is dropped, not held, so the
// sender must re-present the command once cmd_ready returns.
module sm_ramp_ctrl
  import sm_pkg::*;
#(
  parameter int SIZE    = SM_SIZE_DEF,
  parameter int P_START = SM_P_START_DEF,
  parameter int P_MIN   = SM_P_MIN_DEF,
  parameter int P_DEC   = SM_P_DEC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SIZE-1:0] cmd_steps,
  input  logic            cmd_dir,
  input  logic            drv_step,
`ifdef SM_RAMP_ABORT_EN
  input  logic            abort,
`endif
  output logic [SIZE-1:0] n,
  output logic            d_v,
  output logic            drv_en_SM,
  output logic            drv_dir,
  output logic            done
);

  localparam logic [SIZE-1:0] START_W = SIZE'(P_START);
  localparam logic [SIZE-1:0] MIN_W   = SIZE'(P_MIN);
  localparam logic [SIZE-1:0] DEC_W   = SIZE'(P_DEC);
  localparam logic [SIZE-1:0] ONE_W   = SIZE'(1);
  // Smallest n from which a full P_DEC can be subtracted without going below P_MIN.
  localparam logic [SIZE:0]   DEC_FLOOR = {1'b0, MIN_W} + {1'b0, DEC_W};

  sm_state_e       state_q;
  logic [SIZE-1:0] n_q;
  logic            d_v_q;
  logic            en_q;
  logic            dir_q;
  logic            done_q;
  logic [SIZE-1:0] steps_left_q;
  logic [SIZE-1:0] accel_cnt_q;

  logic            step_evt;
  logic [SIZE:0]   inc_sum;
  logic [SIZE-1:0] n_dec_d;
  logic [SIZE-1:0] n_inc_d;
  logic [SIZE-1:0] steps_dec_d;
  logic [SIZE-1:0] acc_inc_d;

  sm_step_edge u_step_edge (
    .clk      (clk),
    .rst      (rst),
    .drv_step (drv_step),
    .step_evt (step_evt)
  );

  // Saturating candidate values used by the FSM on a step event.
  always_comb begin
    inc_sum     = {1'b0, n_q} + {1'b0, DEC_W};
    n_dec_d     = ({1'b0, n_q} >= DEC_FLOOR) ? (n_q - DEC_W) : MIN_W;
    n_inc_d     = (inc_sum >= {1'b0, START_W}) ? START_W : inc_sum[SIZE-1:0];
    steps_dec_d = (steps_left_q != '0) ? (steps_left_q - ONE_W) : '0;
    acc_inc_d   = (&accel_cnt_q) ? accel_cnt_q : (accel_cnt_q + ONE_W);
  end

`ifdef SM_RAMP_ABORT_EN
  logic [SIZE-1:0] cur_left_d;
  logic [SIZE-1:0] cur_acc_d;
  logic [SIZE-1:0] abort_left_d;

  // Steps still needed after an abort: as many as were spent accelerating,
  // but never more than the move had left anyway.
  always_comb begin
    cur_left_d   = step_evt ? steps_dec_d : steps_left_q;
    cur_acc_d    = (step_evt && (state_q == ACCEL)) ? acc_inc_d : accel_cnt_q;
    abort_left_d = (cur_acc_d < cur_left_d) ? cur_acc_d : cur_left_d;
  end
`endif

  // Ramp FSM with registered outputs; d_v and done default low so they pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= START_W;
      d_v_q        <= 1'b0;
      en_q         <= 1'b0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
      accel_cnt_q  <= '0;
    end else begin
      d_v_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_steps != '0) begin
              steps_left_q <= cmd_steps;
              accel_cnt_q  <= '0;
              dir_q        <= cmd_dir;
              n_q          <= START_W;
              d_v_q        <= 1'b1;
              en_q         <= 1'b1;
              state_q      <= ACCEL;
            end else begin
              // Empty move: report completion without ever enabling the driver.
              done_q <= 1'b1;
            end
          end
        end
        ACCEL: begin
          if (step_evt) begin
            steps_left_q <= steps_dec_d;
            accel_cnt_q  <= acc_inc_d;
            n_q          <= n_dec_d;
            d_v_q        <= (n_dec_d != n_q);
            if (steps_dec_d == '0) begin
              state_q <= STOP;
              en_q    <= 1'b0;
              done_q  <= 1'b1;
            end else if (steps_dec_d <= acc_inc_d) begin
              // Only enough steps left to ramp back down: decel wins over cruise.
              state_q <= DECEL;
            end else if (n_dec_d == MIN_W) begin
              state_q <= CRUISE;
            end
          end
        end
        CRUISE: begin
          if (step_evt) begin
            steps_left_q <= steps_dec_d;
            if (steps_dec_d == '0) begin
              state_q <= STOP;
              en_q    <= 1'b0;
              done_q  <= 1'b1;
            end else if (steps_dec_d <= accel_cnt_q) begin
              state_q <= DECEL;
            end
          end
        end
        DECEL: begin
          if (step_evt) begin
            steps_left_q <= steps_dec_d;
            n_q          <= n_inc_d;
            d_v_q        <= (n_inc_d != n_q);
            if (steps_dec_d == '0) begin
              state_q <= STOP;
              en_q    <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        STOP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
`ifdef SM_RAMP_ABORT_EN
      // Abort overrides the step handling above; it only acts while speeding up or cruising.
      if (abort && ((state_q == ACCEL) || (state_q == CRUISE))) begin
        if (abort_left_d == '0) begin
          state_q <= STOP;
          en_q    <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q      <= DECEL;
          steps_left_q <= abort_left_d;
        end
      end
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign n         = n_q;
  assign d_v       = d_v_q;
  assign drv_en_SM = en_q;
  assign drv_dir   = dir_q;
  assign done      = done_q;

endmodule

// File: doc/sm_ramp_ctrl.md
SM_RAMP_CTRL -- requirements
Module: sm_ramp_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 16, width of period and step-count fields.
REQ-002 SHALL have parameter P_START, default 1000, start/stop period in clk cycles.
REQ-003 SHALL have parameter P_MIN, default 100, cruise period in clk cycles (P_MIN <= P_START).
REQ-004 SHALL have parameter P_DEC, default 10, period change applied per step while ramping.
REQ-005 SHALL have port clk, input, 1, the 50 MHz system clock; the block uses one clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port cmd_valid, input, 1, move command strobe.
REQ-008 SHALL have port cmd_ready, output, 1, high when a command is accepted.
REQ-009 SHALL have port cmd_steps, input, SIZE, number of steps to execute.
REQ-010 SHALL have port cmd_dir, input, 1, direction, latched on accept.
REQ-011 SHALL have port drv_step, input, 1, step pulse fed back from the downstream pulse stage.
REQ-012 SHALL have port n, output, SIZE, period for the downstream pulse stage.
REQ-013 SHALL have port d_v, output, 1, one-cycle strobe telling the pulse stage to load n.
REQ-014 SHALL have port drv_en_SM, output, 1, enable for the pulse stage.
REQ-015 SHALL have port drv_dir, output, 1, latched direction.
REQ-016 SHALL have port done, output, 1, one-cycle strobe when a move completes.

Function
REQ-017 SHALL use states IDLE, ACCEL, CRUISE, DECEL, STOP, one-hot encoded.
REQ-018 SHALL assert cmd_ready only in IDLE; cmd_valid outside IDLE is ignored.
REQ-019 On cmd_valid in IDLE with cmd_steps > 0, it SHALL latch steps_left=cmd_steps and drv_dir=cmd_dir, set n=P_START, pulse d_v, assert drv_en_SM the next cycle, and enter ACCEL.
REQ-020 On cmd_valid in IDLE with cmd_steps = 0, it SHALL pulse done the next cycle, keep drv_en_SM low, and stay in IDLE.
REQ-021 A step event SHALL be a rising edge of drv_step, detected by a registered previous value; each event decrements steps_left.
REQ-022 In ACCEL, on each step event it SHALL set n=max(n-P_DEC, P_MIN), increment accel_cnt, and pulse d_v; when n reaches P_MIN it SHALL enter CRUISE.
REQ-023 In ACCEL or CRUISE, when steps_left (after decrement) <= accel_cnt it SHALL enter DECEL; this check has priority over the ACCEL->CRUISE transition.
REQ-024 In DECEL, on each step event it SHALL set n=min(n+P_DEC, P_START) and pulse d_v.
REQ-025 When steps_left reaches 0 in any move state it SHALL enter STOP; STOP SHALL deassert drv_en_SM, pulse done for one cycle, and return to IDLE on the next cycle.
REQ-026 Period arithmetic SHALL saturate and never wrap; accel_cnt SHALL be SIZE bits and saturate at all-ones.
REQ-027 d_v SHALL pulse only when n changes, or at command accept.

Reset
REQ-028 When rst is high at a clk edge, the block SHALL enter IDLE with n=P_START, d_v=0, drv_en_SM=0, drv_dir=0, done=0, and cmd_ready=1 the following cycle; a move in progress is dropped without a done pulse.

Configuration
REQ-029 With macro SM_RAMP_ABORT_EN defined, it SHALL add input abort (1 bit); abort in ACCEL or CRUISE forces DECEL with steps_left=accel_cnt, and abort in IDLE, DECEL or STOP is ignored.
REQ-030 Without SM_RAMP_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-031 The state encodings and default P_START/P_MIN/P_DEC SHALL live in shared package sm_pkg, together with the pulse stage's constants.
REQ-032 The step edge detector SHALL be sub-module sm_step_edge (inputs clk, rst, drv_step; output step_evt).

Verification
REQ-033 With P_START=1000, P_MIN=100, P_DEC=100 and cmd_steps=40: n SHALL go 1000..100 over 9 steps, hold 100 through step 31, rise to 1000 by step 40, then done pulses once and drv_en_SM falls.
REQ-034 Same parameters, cmd_steps=6: n SHALL go 900, 800, 700, 800, 900, then done after step 6, with no CRUISE state.
REQ-035 cmd_steps=0: done SHALL pulse one cycle after accept, with drv_en_SM never high and no d_v.
REQ-036 cmd_valid asserted mid-move with cmd_steps=5: it SHALL be ignored, cmd_ready=0, and the step total SHALL equal the original command.
REQ-037 rst asserted during CRUISE: the next cycle SHALL show IDLE, drv_en_SM=0, n=1000, and no done.
REQ-038 With SM_RAMP_ABORT_EN, abort at step 20 of the 40-step move: decel SHALL run 9 steps, giving 29 steps total, then done.
